// File: rtl/uart_block_tx.sv
// Block transmitter: buffers BLOCK_LEN bytes, then sends them 8N1 (LSB first)
// followed by one checksum byte holding the modular sum of the block.
module uart_block_tx #(
    parameter int unsigned N_DATA_BITS = 8,
    parameter int unsigned BLOCK_LEN   = 16,
    parameter int unsigned OVERSAMPLE  = 13
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_en,
    input  logic                   i_wr_valid,
    input  logic [N_DATA_BITS-1:0] i_wr_data,
    output logic                   o_wr_ready,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [N_DATA_BITS-1:0] o_checksum,
    output logic                   o_uart_tx
);

    localparam int unsigned PTR_W  = $clog2(BLOCK_LEN) + 1;
    localparam int unsigned ADDR_W = PTR_W - 1;
    localparam int unsigned CNT_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BLOCK_LEN - 1);
    localparam logic [PTR_W-1:0] CSUM_IDX  = PTR_W'(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(N_DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_ARMED,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]       tick_q, tick_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rdy_q, rdy_d;
    logic [N_DATA_BITS-1:0] csum_q, csum_d;

    logic [N_DATA_BITS-1:0] mem [BLOCK_LEN];

    logic                   wr_fire;
    logic                   bit_end;
    logic [BIT_W-1:0]       bit_nx;
    logic [N_DATA_BITS-1:0] cur_byte;

    // Write acceptance, end-of-bit tick, and the byte currently on the line
    always_comb begin
        wr_fire  = i_wr_valid && rdy_q;
        bit_end  = i_en && (tick_q == LAST_TICK);
        bit_nx   = bit_q + BIT_W'(1);
        cur_byte = (byte_idx_q == CSUM_IDX) ? csum_q : mem[byte_idx_q[ADDR_W-1:0]];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_idx_d = byte_idx_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rdy_d      = rdy_q;
        csum_d     = csum_q;

        // First write of a block restarts the sum so the previous one stays visible until then
        if (wr_fire) begin
            ptr_d  = ptr_q + PTR_W'(1);
            csum_d = (ptr_q == '0) ? i_wr_data : csum_q + i_wr_data;
        end

        if ((state_q == S_START || state_q == S_DATA || state_q == S_STOP) && i_en) begin
            tick_d = bit_end ? '0 : tick_q + CNT_W'(1);
        end

        unique case (state_q)
            S_FILL: begin
                if (wr_fire && ptr_q == LAST_PTR) begin
                    state_d = S_ARMED;
                    rdy_d   = 1'b0;
                end
            end
            S_ARMED: begin
                if (i_start) begin
                    state_d    = S_WAIT;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                end
            end
            S_WAIT: begin
                if (i_en) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = cur_byte[bit_nx];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != CSUM_IDX) begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + PTR_W'(1);
                        tx_d       = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_FILL;
                rdy_d   = 1'b1;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= S_FILL;
            ptr_q      <= '0;
            byte_idx_q <= '0;
            tick_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b1;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_idx_q <= byte_idx_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdy_q      <= rdy_d;
            csum_q     <= csum_d;
        end
    end

    // Block buffer; contents need no reset
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem[ptr_q[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    assign o_uart_tx  = tx_q;
    assign o_wr_ready = rdy_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_checksum = csum_q;

endmodule

// File: doc/uart_block_tx.md
# uart_block_tx

Transmit-side counterpart of the UART block receiver and summer. It buffers a block of BLOCK_LEN bytes written by local logic. On command it serialises the block over a UART TX line (8N1, LSB first), then appends one checksum byte: the 8-bit modular sum of the block. It shares the receiver's oversampling enable scheme, so it runs from the same `i_clk`/`i_en` tick as `uart_rx`.

## Interface
- `N_DATA_BITS`, 8: bits per data byte and checksum width.
- `BLOCK_LEN`, 16: bytes per block (power of two, 2..256).
- `OVERSAMPLE`, 13: `i_en` ticks per UART bit.
- `i_clk`, in, 1: single clock for the whole block.
- `i_reset`, in, 1: synchronous, active-low reset.
- `i_en`, in, 1: one-cycle oversample tick; may be high every cycle.
- `i_wr_valid`, in, 1: write strobe for `i_wr_data`.
- `i_wr_data`, in, N_DATA_BITS: byte to append to the buffer.
- `o_wr_ready`, out, 1: buffer accepts a write this cycle.
- `i_start`, in, 1: start transmission (level sampled each cycle).
- `o_busy`, out, 1: high from start acceptance until the checksum stop bit ends.
- `o_done`, out, 1: one-cycle pulse when the packet completes.
- `o_checksum`, out, N_DATA_BITS: running sum during fill; holds the last packet's sum after done until the next write.
- `o_uart_tx`, out, 1: serial line, idle high.

## Operation
- Buffer: BLOCK_LEN x N_DATA_BITS storage with a write pointer of width $clog2(BLOCK_LEN)+1.
- A write occurs when `i_wr_valid && o_wr_ready`. It stores at the pointer, increments the pointer, and adds the byte to the checksum modulo 2^N_DATA_BITS.
- States:
  - FILL: `o_wr_ready`=1. Moves to ARMED the cycle after the BLOCK_LEN-th write.
  - ARMED: `o_wr_ready`=0. On `i_start`=1, moves to WAIT, sets `o_busy`=1, and sets byte index=0.
  - WAIT: moves to START on the next `i_en`.
  - START: `o_uart_tx`=0 for OVERSAMPLE ticks.
  - DATA: drives bits 0..N_DATA_BITS-1 of the current byte, OVERSAMPLE ticks each.
  - STOP: `o_uart_tx`=1 for OVERSAMPLE ticks. Then either the next byte's START (index < BLOCK_LEN), or DONE.
  - DONE: for one cycle `o_done`=1, `o_busy`=0, pointer=0. Moves to FILL.
- Byte source: indices 0..BLOCK_LEN-1 come from the buffer in write order. Index BLOCK_LEN is the checksum byte.
- Tick counter: counts `i_en` 0..OVERSAMPLE-1 within each bit. The bit advances on the tick where the count equals OVERSAMPLE-1. Cycles without `i_en` hold all state.
- Frames are back-to-back with no extra idle between them.
- Checksum: cleared on the first write after DONE (not at DONE itself), so `o_checksum` stays readable.
- Ignored inputs:
  - `i_start` outside ARMED.
  - `i_wr_valid` when `o_wr_ready`=0, including the ARMED and busy states. Data is dropped and the pointer holds.
  - `i_start` in the same cycle as the last write; the block is not ARMED yet.
- Reset (`i_reset`=0 at a clock edge):
  - Takes effect at any state, including mid-bit.
  - Next cycle: `o_uart_tx`=1, `o_wr_ready`=1, `o_busy`=0, `o_done`=0, `o_checksum`=0, pointer=0, state FILL.
  - Buffer contents are don't-care.

## Timing
- Reset values: `o_uart_tx`=1, `o_wr_ready`=1, `o_busy`=0, `o_done`=0, `o_checksum`=0.
- Write: `o_checksum` reflects the write one cycle later. `o_wr_ready` drops the cycle after the BLOCK_LEN-th write.
- Start: `o_busy` rises the cycle after `i_start` is accepted. `o_uart_tx` falls the cycle after the first subsequent `i_en`.
- Frame length: 10·OVERSAMPLE ticks.
- Packet length: (BLOCK_LEN+1)·10·OVERSAMPLE ticks, which is 2210 ticks at default parameters.
- `o_done` is asserted the cycle after the final STOP tick. `o_busy` falls the same cycle.
- Registered outputs only; `o_uart_tx` comes straight from a flop (glitch-free).

## Test plan
- **Basic packet.** Write 0x01..0x10, pulse `i_start`, hold `i_en`=1.
  - Line decodes to 0x01..0x10, then 0x88.
  - Each bit is 13 cycles; `o_done` comes 2210 cycles after the start bit.
- **Checksum wrap.** Write 16×0xFF.
  - `o_checksum`=0xF0, and the checksum frame carries 0xF0.
  - Next fill of 16×0x00 gives 0x00; 0xF0 is held until the first new write.
- **Overflow and early start.**
  - `i_start` after 15 writes: ignored.
  - 17th write (0xAA): dropped, `o_wr_ready`=0.
  - Transmitted block excludes 0xAA.
- **Start while busy.** Pulse `i_start` mid-packet.
  - Exactly 17 frames are sent, one `o_done`, and no restart.
- **Sparse tick.** `i_en` once every 64 cycles.
  - Bit width is 832 cycles; the line holds between ticks.
  - Output is identical to the basic packet when sampled at bit centres.
- **Reset mid-operation.** Assert `i_reset`=0 in the DATA state of frame 5.
  - Next cycle: `o_uart_tx`=1, `o_busy`=0, `o_wr_ready`=1, `o_checksum`=0.
  - A fresh 16-byte fill and start then transmit correctly.
